memory_unit: RTL and testbench

//  - Byte-serial RAM controller directly downstream of the load/store buffer; shares one RAM port with instruction fetch.
//  - Serves one request at a time: LSB loads and stores of 1, 2 or 4 bytes, and 4-byte fetches from the IF stage.
//  - Returns raw little-endian data; the LSB performs sign and zero extension.

---
 rtl/memory_unit.sv | 235 +++++++++++++++++++++++
 tb/tb_memory_unit.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_unit.sv
// Byte-serial RAM controller shared by LSB loads/stores and IF word fetches. Optional IO store stall under MEMORY_UNIT_IO_STALL_EN.
// Latency: load/fetch pulse n+2 cycles after accept, store pulse n+1 cycles after accept (n = 1/2/4 bytes).
// Backpressure: busy holds off the LSB, if_req stays pending until if_done; rdy_in=0 freezes everything.
module memory_unit #(
    parameter int         POS_W = 3,
    parameter logic [1:0] IO_HI = 2'b11
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             clear,
    input  logic             lsb_req,
    input  logic [POS_W-1:0] lsb_pos,
    input  logic             lsb_ls,
    input  logic [1:0]       lsb_len,
    input  logic [31:0]      lsb_addr,
    input  logic [31:0]      lsb_val,
    output logic             busy,
    output logic             lsb_finished,
    output logic [POS_W-1:0] lsb_pos_out,
    output logic [31:0]      lsb_val_out,
    input  logic             if_req,
    input  logic [31:0]      if_addr,
    output logic             if_done,
    output logic [31:0]      if_inst,
    input  logic [7:0]       mem_din,
    output logic [7:0]       mem_dout,
    output logic [31:0]      mem_a,
    output logic             mem_wr,
    input  logic             io_buffer_full
);

    typedef enum logic [1:0] {IDLE, LOAD, STORE, FETCH} state_t;

    state_t           state_q, state_d;
    logic [2:0]       cnt_q;
    logic [2:0]       n_q;
    logic [POS_W-1:0] pos_q;
    logic [31:0]      addr_q;
    logic [31:0]      val_q;
    logic [31:0]      buf_q;
    logic [31:0]      mem_a_q;
    logic [31:0]      a_prev_q;
    logic [7:0]       mem_dout_q;
    logic             wr_q;
    logic             lsb_finished_q;
    logic [POS_W-1:0] lsb_pos_out_q;
    logic [31:0]      lsb_val_out_q;
    logic             if_done_q;
    logic [31:0]      if_inst_q;

    logic        accept_lsb;
    logic        accept_if;
    logic        is_rd;
    logic        rd_last;
    logic        rd_end;
    logic        st_last;
    logic        st_end;
    logic        io_stall;
    logic        step;
    logic [2:0]  n_dec;
    logic [1:0]  bidx;
    logic [1:0]  nidx;
    logic [31:0] next_a;
    logic [31:0] buf_next;
    logic [7:0]  store_byte;

    assign accept_lsb = (state_q == IDLE) && lsb_req && (lsb_ls || !clear);
    assign accept_if  = (state_q == IDLE) && !lsb_req && if_req && !clear;
    assign is_rd      = (state_q == LOAD) || (state_q == FETCH);
    assign rd_last    = is_rd && (cnt_q == n_q);
    assign rd_end     = is_rd && (cnt_q == n_q + 3'd1);
    assign st_last    = (state_q == STORE) && (cnt_q == n_q - 3'd1);
    assign st_end     = (state_q == STORE) && (cnt_q == n_q);

`ifdef MEMORY_UNIT_IO_STALL_EN
    // The pending byte's own address decides the stall, so a store crossing into IO space stalls only there.
    assign io_stall = (state_q == STORE) && wr_q && (mem_a_q[17:16] == IO_HI) && io_buffer_full;
`else
    logic unused_io;
    assign io_stall  = 1'b0;
    assign unused_io = io_buffer_full ^ (^IO_HI);
`endif

    assign step = rdy_in && !io_stall;

    always_comb begin
        n_dec = 3'd4;
        case (lsb_len)
            2'b00:   n_dec = 3'd1;
            2'b01:   n_dec = 3'd2;
            default: n_dec = 3'd4;
        endcase
    end

    // Byte cnt-1 arrives on mem_din in the cycle where cnt is current (one-cycle RAM latency).
    assign bidx       = cnt_q[1:0] - 2'd1;
    assign nidx       = cnt_q[1:0] + 2'd1;
    assign next_a     = addr_q + {29'd0, cnt_q} + 32'd1;
    assign store_byte = val_q[{nidx, 3'b000} +: 8];

    always_comb begin
        buf_next = buf_q;
        buf_next[{bidx, 3'b000} +: 8] = mem_din;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
        end else if (step) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_lsb) begin
                    state_d = lsb_ls ? STORE : LOAD;
                end else if (accept_if) begin
                    state_d = FETCH;
                end
            end
            LOAD, FETCH: begin
                if (clear || rd_end) begin
                    state_d = IDLE;
                end
            end
            STORE: begin
                if (st_end) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // While paused the RAM keeps seeing the last issued address, so the byte it returns on resume is still the expected one.
    always_comb begin
        busy         = rst_in || (state_q != IDLE) || lsb_req;
        mem_wr       = wr_q && rdy_in && !rst_in && !io_stall;
        mem_a        = rdy_in ? mem_a_q : a_prev_q;
        mem_dout     = mem_dout_q;
        lsb_finished = lsb_finished_q;
        lsb_pos_out  = lsb_pos_out_q;
        lsb_val_out  = lsb_val_out_q;
        if_done      = if_done_q;
        if_inst      = if_inst_q;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_q          <= 3'd0;
            n_q            <= 3'd0;
            pos_q          <= '0;
            addr_q         <= 32'd0;
            val_q          <= 32'd0;
            buf_q          <= 32'd0;
            mem_a_q        <= 32'd0;
            a_prev_q       <= 32'd0;
            mem_dout_q     <= 8'd0;
            wr_q           <= 1'b0;
            lsb_finished_q <= 1'b0;
            lsb_pos_out_q  <= '0;
            lsb_val_out_q  <= 32'd0;
            if_done_q      <= 1'b0;
            if_inst_q      <= 32'd0;
        end else if (step) begin
            lsb_finished_q <= 1'b0;
            if_done_q      <= 1'b0;
            a_prev_q       <= mem_a_q;
            case (state_q)
                IDLE: begin
                    if (accept_lsb) begin
                        cnt_q      <= 3'd0;
                        n_q        <= n_dec;
                        pos_q      <= lsb_pos;
                        addr_q     <= lsb_addr;
                        val_q      <= lsb_val;
                        buf_q      <= 32'd0;
                        mem_a_q    <= lsb_addr;
                        mem_dout_q <= lsb_val[7:0];
                        wr_q       <= lsb_ls;
                    end else if (accept_if) begin
                        cnt_q   <= 3'd0;
                        n_q     <= 3'd4;
                        addr_q  <= if_addr;
                        buf_q   <= 32'd0;
                        mem_a_q <= if_addr;
                        wr_q    <= 1'b0;
                    end
                end
                LOAD, FETCH: begin
                    if (!clear && !rd_end) begin
                        cnt_q <= cnt_q + 3'd1;
                        if (cnt_q != 3'd0) begin
                            buf_q <= buf_next;
                        end
                        if (cnt_q + 3'd1 < n_q) begin
                            mem_a_q <= next_a;
                        end
                        if (rd_last) begin
                            if (state_q == LOAD) begin
                                lsb_finished_q <= 1'b1;
                                lsb_pos_out_q  <= pos_q;
                                lsb_val_out_q  <= buf_next;
                            end else begin
                                if_done_q <= 1'b1;
                                if_inst_q <= buf_next;
                            end
                        end
                    end
                end
                STORE: begin
                    if (!st_end) begin
                        cnt_q <= cnt_q + 3'd1;
                        if (st_last) begin
                            wr_q           <= 1'b0;
                            lsb_finished_q <= 1'b1;
                            lsb_pos_out_q  <= pos_q;
                            lsb_val_out_q  <= 32'd0;
                        end else begin
                            mem_a_q    <= next_a;
                            mem_dout_q <= store_byte;
                            wr_q       <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_unit.sv
// Directed bench for memory_unit with a one-cycle-latency byte RAM model.
module tb_memory_unit;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic        rst_in, rdy_in, clear, lsb_req, lsb_ls, if_req, io_buffer_full;
    logic [2:0]  lsb_pos;
    logic [1:0]  lsb_len;
    logic [31:0] lsb_addr, lsb_val, if_addr;
    logic        busy, lsb_finished, if_done, mem_wr;
    logic [2:0]  lsb_pos_out;
    logic [31:0] lsb_val_out, if_inst, mem_a;
    logic [7:0]  mem_din, mem_dout;

    memory_unit dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .lsb_req(lsb_req), .lsb_pos(lsb_pos), .lsb_ls(lsb_ls), .lsb_len(lsb_len),
        .lsb_addr(lsb_addr), .lsb_val(lsb_val), .busy(busy),
        .lsb_finished(lsb_finished), .lsb_pos_out(lsb_pos_out), .lsb_val_out(lsb_val_out),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_inst(if_inst),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    logic [7:0]  ram [0:262143];
    logic        pl_en;
    logic [17:0] pl_addr;
    logic [7:0]  pl_dat;

    always @(posedge clk_in) begin
        if (pl_en) ram[pl_addr] <= pl_dat;
        else if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
        mem_din <= ram[mem_a[17:0]];
    end

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    typedef struct { int c; logic [31:0] a; logic [31:0] d; } ev_t;
    ev_t fin_q[$];
    ev_t done_q[$];
    ev_t wr_log[$];
    logic        busy_h [0:4095];
    logic [31:0] val_h  [0:4095];
    logic [31:0] ma_h   [0:4095];

    always @(negedge clk_in) begin
        if (cyc < 4096) begin
            busy_h[cyc] = busy;
            val_h[cyc]  = lsb_val_out;
            ma_h[cyc]   = mem_a;
        end
        if (lsb_finished) fin_q.push_back('{cyc, {29'd0, lsb_pos_out}, lsb_val_out});
        if (if_done)      done_q.push_back('{cyc, 32'd0, if_inst});
        if (mem_wr)       wr_log.push_back('{cyc, mem_a, {24'd0, mem_dout}});
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic clear_logs();
        fin_q.delete();
        done_q.delete();
        wr_log.delete();
    endtask

    task automatic preload(input logic [17:0] a, input logic [7:0] d);
        pl_en = 1'b1; pl_addr = a; pl_dat = d;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic lsb_go(input logic ls, input logic [1:0] len, input logic [31:0] a,
                          input logic [31:0] v, input logic [2:0] p);
        lsb_req = 1'b1; lsb_ls = ls; lsb_len = len; lsb_addr = a; lsb_val = v; lsb_pos = p;
    endtask

    task automatic chk_fin(input string tag, input int base, input int dc,
                           input logic [31:0] val, input logic [31:0] pos);
        check({tag, "_nfin"}, 32'(fin_q.size()), 32'd1);
        if (fin_q.size() > 0) begin
            check({tag, "_fcyc"}, 32'(fin_q[0].c - base), 32'(dc));
            check({tag, "_val"},  fin_q[0].d, val);
            check({tag, "_pos"},  fin_q[0].a, pos);
        end
    endtask

    task automatic chk_wr(input string tag, input int idx, input int base, input int dc,
                          input logic [31:0] a, input logic [7:0] d);
        if (wr_log.size() > idx) begin
            check({tag, "_wcyc"}, 32'(wr_log[idx].c - base), 32'(dc));
            check({tag, "_wadr"}, wr_log[idx].a, a);
            check({tag, "_wdat"}, wr_log[idx].d, {24'd0, d});
        end
    endtask

    initial begin
        int base;
        int lows;
        logic [7:0] sw_bytes [4];
        sw_bytes = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};

        rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0; lsb_req = 1'b0; lsb_ls = 1'b0;
        lsb_len = 2'b00; lsb_addr = 32'd0; lsb_val = 32'd0; lsb_pos = 3'd0;
        if_req = 1'b0; if_addr = 32'd0; io_buffer_full = 1'b0;
        pl_en = 1'b0; pl_addr = 18'd0; pl_dat = 8'd0;

        // reset state
        repeat (3) tick();
        @(negedge clk_in);
        check("rst_busy",   {31'd0, busy}, 32'd1);
        check("rst_fin",    {31'd0, lsb_finished}, 32'd0);
        check("rst_val",    lsb_val_out, 32'd0);
        check("rst_pos",    {29'd0, lsb_pos_out}, 32'd0);
        check("rst_done",   {31'd0, if_done}, 32'd0);
        check("rst_inst",   if_inst, 32'd0);
        check("rst_mem_a",  mem_a, 32'd0);
        check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        check("rst_dout",   {24'd0, mem_dout}, 32'd0);
        tick();
        rst_in = 1'b0;
        @(negedge clk_in);
        check("idle_busy", {31'd0, busy}, 32'd0);

        preload(18'h100, 8'h11);
        preload(18'h101, 8'h22);
        preload(18'h102, 8'h33);
        preload(18'h103, 8'h44);

        // LW 0x100
        clear_logs(); tick(); base = cyc;
        lsb_go(1'b0, 2'b10, 32'h100, 32'd0, 3'd5);
        tick(); lsb_req = 1'b0;
        repeat (10) tick();
        chk_fin("lw", base, 6, 32'h44332211, 32'd5);
        check("lw_nwr", 32'(wr_log.size()), 32'd0);
        check("lw_busy_c6", {31'd0, busy_h[base + 6]}, 32'd1);
        check("lw_busy_c7", {31'd0, busy_h[base + 7]}, 32'd0);

        // LH 0x102, zero-filled upper half
        clear_logs(); tick(); base = cyc;
        lsb_go(1'b0, 2'b01, 32'h102, 32'd0, 3'd2);
        tick(); lsb_req = 1'b0;
        repeat (8) tick();
        chk_fin("lh", base, 4, 32'h00004433, 32'd2);

        // SH 0xABCD1234 at 0x203, misaligned
        clear_logs(); tick(); base = cyc;
        lsb_go(1'b1, 2'b01, 32'h203, 32'hABCD1234, 3'd2);
        tick(); lsb_req = 1'b0;
        repeat (8) tick();
        check("sh_nwr", 32'(wr_log.size()), 32'd2);
        chk_wr("sh0", 0, base, 1, 32'h203, 8'h34);
        chk_wr("sh1", 1, base, 2, 32'h204, 8'h12);
        chk_fin("sh", base, 3, 32'd0, 32'd2);
        check("sh_ram", {24'd0, ram[18'h204]}, 32'h12);

        // LSB and IF in the same cycle: LSB wins, fetch follows
        clear_logs(); tick(); base = cyc;
        lsb_go(1'b0, 2'b00, 32'h101, 32'd0, 3'd1);
        if_req = 1'b1; if_addr = 32'h100;
        tick(); lsb_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done_q.size() != 0) if_req = 1'b0;
        end
        chk_fin("dual_lb", base, 3, 32'h22, 32'd1);
        check("dual_ndone", 32'(done_q.size()), 32'd1);
        if (done_q.size() > 0) begin
            check("dual_dcyc", 32'(done_q[0].c - base), 32'd10);
            check("dual_inst", done_q[0].d, 32'h44332211);
        end
        lows = 0;
        for (int i = 0; i <= 10; i++)
            if (i != 4 && !busy_h[base + i]) lows++;
        check("dual_busy_low", 32'(lows), 32'd0);

        // LW paused cycles 2-4
        clear_logs(); tick(); base = cyc;
        lsb_go(1'b0, 2'b10, 32'h100, 32'd0, 3'd7);
        tick(); lsb_req = 1'b0;
        tick(); rdy_in = 1'b0;
        repeat (3) tick();
        rdy_in = 1'b1;
        repeat (10) tick();
        chk_fin("pause", base, 9, 32'h44332211, 32'd7);
        check("pause_nwr", 32'(wr_log.size()), 32'd0);
        check("pause_val_c3", val_h[base + 3], 32'h22);
        check("pause_val_c8", val_h[base + 8], 32'h22);

        // clear during LW
        clear_logs(); tick(); base = cyc;
        lsb_go(1'b0, 2'b10, 32'h100, 32'd0, 3'd3);
        tick(); lsb_req = 1'b0;
        repeat (2) tick();
        clear = 1'b1;
        tick(); clear = 1'b0;
        repeat (8) tick();
        check("clr_lw_nfin", 32'(fin_q.size()), 32'd0);
        check("clr_lw_busy4", {31'd0, busy_h[base + 4]}, 32'd0);

        // clear during fetch
        clear_logs(); tick(); base = cyc;
        if_req = 1'b1; if_addr = 32'h100;
        repeat (3) tick();
        clear = 1'b1; if_req = 1'b0;
        tick(); clear = 1'b0;
        repeat (8) tick();
        check("clr_if_ndone", 32'(done_q.size()), 32'd0);
        check("clr_if_busy4", {31'd0, busy_h[base + 4]}, 32'd0);

        // clear during SW has no effect
        clear_logs(); tick(); base = cyc;
        lsb_go(1'b1, 2'b10, 32'h300, 32'hDEADBEEF, 3'd4);
        tick(); lsb_req = 1'b0;
        tick(); clear = 1'b1;
        tick(); clear = 1'b0;
        repeat (8) tick();
        check("clr_sw_nwr", 32'(wr_log.size()), 32'd4);
        for (int k = 0; k < 4; k++)
            chk_wr($sformatf("clr_sw%0d", k), k, base, k + 1, 32'h300 + 32'(k), sw_bytes[k]);
        chk_fin("clr_sw", base, 5, 32'd0, 32'd4);

        // SB to IO space with full UART buffer during cycles 0-3
        clear_logs(); tick(); base = cyc;
        lsb_go(1'b1, 2'b00, 32'h30000, 32'h41, 3'd6);
        io_buffer_full = 1'b1;
        tick(); lsb_req = 1'b0;
        repeat (3) tick();
        io_buffer_full = 1'b0;
        repeat (8) tick();
        check("io_nwr", 32'(wr_log.size()), 32'd1);
`ifdef MEMORY_UNIT_IO_STALL_EN
        chk_wr("io", 0, base, 4, 32'h30000, 8'h41);
        chk_fin("io", base, 5, 32'd0, 32'd6);
`else
        chk_wr("io", 0, base, 1, 32'h30000, 8'h41);
        chk_fin("io", base, 2, 32'd0, 32'd6);
`endif

        // clear in IDLE: load dropped
        clear_logs(); tick(); base = cyc;
        lsb_go(1'b0, 2'b10, 32'h100, 32'd0, 3'd3);
        clear = 1'b1;
        tick(); lsb_req = 1'b0; clear = 1'b0;
        repeat (8) tick();
        check("idle_clr_ld_nfin", 32'(fin_q.size()), 32'd0);
        check("idle_clr_ld_busy1", {31'd0, busy_h[base + 1]}, 32'd0);

        // clear in IDLE: store still accepted
        clear_logs(); tick(); base = cyc;
        lsb_go(1'b1, 2'b00, 32'h400, 32'h5A, 3'd1);
        clear = 1'b1;
        tick(); lsb_req = 1'b0; clear = 1'b0;
        repeat (6) tick();
        check("idle_clr_st_nwr", 32'(wr_log.size()), 32'd1);
        chk_wr("idle_clr_st", 0, base, 1, 32'h400, 8'h5A);
        chk_fin("idle_clr_st", base, 2, 32'd0, 32'd1);

        // LW wrapping past 0xFFFFFFFF
        preload(18'h3FFFE, 8'hAA);
        preload(18'h3FFFF, 8'hBB);
        preload(18'h00000, 8'hCC);
        preload(18'h00001, 8'hDD);
        clear_logs(); tick(); base = cyc;
        lsb_go(1'b0, 2'b10, 32'hFFFFFFFE, 32'd0, 3'd0);
        tick(); lsb_req = 1'b0;
        repeat (10) tick();
        chk_fin("wrap", base, 6, 32'hDDCCBBAA, 32'd0);
        check("wrap_mem_a_c3", ma_h[base + 3], 32'h00000000);

        // reset in the middle of a SW
        clear_logs(); tick(); base = cyc;
        lsb_go(1'b1, 2'b10, 32'h500, 32'h11223344, 3'd2);
        tick(); lsb_req = 1'b0;
        tick(); rst_in = 1'b1;
        tick(); rst_in = 1'b0;
        repeat (8) tick();
        check("rst_mid_nwr", 32'(wr_log.size()), 32'd1);
        chk_wr("rst_mid", 0, base, 1, 32'h500, 8'h44);
        check("rst_mid_nfin", 32'(fin_q.size()), 32'd0);
        check("rst_mid_busy3", {31'd0, busy_h[base + 3]}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
